// File: rtl/mii_net.sv
// MII transmit test-frame generator: periodically sends a minimum-size broadcast
// frame carrying the switch state. Optional sequence number under MII_NET_SEQNUM_EN.
module mii_net #(
  parameter int          FRAME_PERIOD = 1000,
  parameter logic [47:0] SRC_MAC      = 48'h02_00_00_00_00_01,
  parameter logic [15:0] ETHERTYPE    = 16'h88B5
) (
  input  logic        i_sys_clk,
  input  logic        i_nreset,
  input  logic [16:0] i_switches,
  output logic [3:0]  o_mii_txd,
  output logic        o_mii_tx_en,
  output logic        o_busy,
  output logic [15:0] o_frame_count
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_PREAMBLE = 2'd1;
  localparam logic [1:0] S_DATA     = 2'd2;
  localparam logic [1:0] S_FCS      = 2'd3;

  localparam int             CW         = (FRAME_PERIOD > 2) ? $clog2(FRAME_PERIOD) : 1;
  localparam logic [CW-1:0]  CNT_LAST   = CW'(FRAME_PERIOD - 1);
  localparam logic [7:0]     LAST_NIB   = 8'd143;
  localparam logic [7:0]     FIRST_DATA = 8'd16;
  localparam logic [7:0]     FIRST_FCS  = 8'd136;
  localparam logic [31:0]    CRC_POLY   = 32'hEDB88320;
  localparam logic [31:0]    CRC_INIT   = 32'hFFFFFFFF;

  // Reflected CRC-32 advanced by one nibble, bit 0 first.
  function automatic logic [31:0] crc_nibble(input logic [31:0] c, input logic [3:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 4; i++) begin
      if (r[0] ^ d[i]) begin
        r = {1'b0, r[31:1]} ^ CRC_POLY;
      end else begin
        r = {1'b0, r[31:1]};
      end
    end
    return r;
  endfunction

  // Nibble k of the wire frame up to the end of the pad; low nibble of each byte first.
  function automatic logic [3:0] frame_nibble(input logic [7:0] k, input logic [16:0] sw,
                                              input logic [15:0] seq);
    logic [7:0] b;
    case (k[7:1])
      7'd0, 7'd1, 7'd2, 7'd3, 7'd4, 7'd5, 7'd6: b = 8'h55;
      7'd7:  b = 8'hD5;
      7'd8, 7'd9, 7'd10, 7'd11, 7'd12, 7'd13: b = 8'hFF;
      7'd14: b = SRC_MAC[47:40];
      7'd15: b = SRC_MAC[39:32];
      7'd16: b = SRC_MAC[31:24];
      7'd17: b = SRC_MAC[23:16];
      7'd18: b = SRC_MAC[15:8];
      7'd19: b = SRC_MAC[7:0];
      7'd20: b = ETHERTYPE[15:8];
      7'd21: b = ETHERTYPE[7:0];
      7'd22: b = {7'b0000000, sw[16]};
      7'd23: b = sw[15:8];
      7'd24: b = sw[7:0];
      7'd25: b = seq[15:8];
      7'd26: b = seq[7:0];
      default: b = 8'h00;
    endcase
    return k[0] ? b[7:4] : b[3:0];
  endfunction

  logic [1:0]    state;
  logic [7:0]    nib_idx;
  logic [CW-1:0] period_cnt;
  logic [16:0]   sw_lat;
  logic [31:0]   crc;
  logic [15:0]   seq_word;

  logic [1:0]    state_nx;
  logic [7:0]    idx_nx;
  logic [7:0]    idx_inc;
  logic [31:0]   crc_nx;
  logic [3:0]    txd_nx;
  logic          en_nx;
  logic [15:0]   count_nx;
  logic [16:0]   sw_nx;
  logic [3:0]    data_nib;
  logic          frame_start;

  assign frame_start = (state == S_IDLE) && (period_cnt == '0);

`ifdef MII_NET_SEQNUM_EN
  logic [15:0] seq_lat;

  // Sequence number is the completed-frame count at the moment this frame starts.
  always_ff @(posedge i_sys_clk or negedge i_nreset) begin
    if (!i_nreset) begin
      seq_lat <= 16'h0000;
    end else if (frame_start) begin
      seq_lat <= o_frame_count;
    end else begin
      seq_lat <= seq_lat;
    end
  end

  assign seq_word = seq_lat;
`else
  assign seq_word = 16'h0000;
`endif

  // Next-state and next-output decode; outputs are loaded one nibble ahead of the index.
  always_comb begin
    state_nx = state;
    idx_nx   = nib_idx;
    crc_nx   = crc;
    txd_nx   = 4'h0;
    en_nx    = 1'b0;
    count_nx = o_frame_count;
    sw_nx    = sw_lat;
    idx_inc  = nib_idx + 8'd1;
    data_nib = frame_nibble(idx_inc, sw_lat, seq_word);
    case (state)
      S_IDLE: begin
        if (frame_start) begin
          state_nx = S_PREAMBLE;
          idx_nx   = 8'd0;
          crc_nx   = CRC_INIT;
          sw_nx    = i_switches;
          txd_nx   = frame_nibble(8'd0, i_switches, 16'h0000);
          en_nx    = 1'b1;
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_PREAMBLE, S_DATA, S_FCS: begin
        if (nib_idx == LAST_NIB) begin
          state_nx = S_IDLE;
          count_nx = o_frame_count + 16'd1;
        end else begin
          idx_nx = idx_inc;
          en_nx  = 1'b1;
          if (idx_inc >= FIRST_FCS) begin
            state_nx = S_FCS;
            txd_nx   = ~crc[3:0];
            crc_nx   = {4'h0, crc[31:4]};
          end else if (idx_inc >= FIRST_DATA) begin
            state_nx = S_DATA;
            txd_nx   = data_nib;
            crc_nx   = crc_nibble(crc, data_nib);
          end else begin
            state_nx = S_PREAMBLE;
            txd_nx   = data_nib;
          end
        end
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // Free-running period counter; frames start only when it reads zero.
  always_ff @(posedge i_sys_clk or negedge i_nreset) begin
    if (!i_nreset) begin
      period_cnt <= '0;
    end else if (period_cnt == CNT_LAST) begin
      period_cnt <= '0;
    end else begin
      period_cnt <= period_cnt + CW'(1);
    end
  end

  // Frame state and registered MII outputs; reset aborts any frame in flight.
  always_ff @(posedge i_sys_clk or negedge i_nreset) begin
    if (!i_nreset) begin
      state         <= S_IDLE;
      nib_idx       <= 8'd0;
      crc           <= CRC_INIT;
      sw_lat        <= 17'd0;
      o_mii_txd     <= 4'h0;
      o_mii_tx_en   <= 1'b0;
      o_busy        <= 1'b0;
      o_frame_count <= 16'd0;
    end else begin
      state         <= state_nx;
      nib_idx       <= idx_nx;
      crc           <= crc_nx;
      sw_lat        <= sw_nx;
      o_mii_txd     <= txd_nx;
      o_mii_tx_en   <= en_nx;
      o_busy        <= en_nx;
      o_frame_count <= count_nx;
    end
  end

endmodule

// File: tb/tb_mii_net.sv
// Directed bench for mii_net: reset state, frame contents, CRC residue, period,
// switch latching, mid-frame reset and (with MII_NET_SEQNUM_EN) sequence numbers.
module tb_mii_net;

  localparam int          P   = 200;
  localparam logic [47:0] MAC = 48'h02_00_00_00_00_01;
  localparam logic [15:0] ET  = 16'h88B5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [16:0] sw = 17'h0AAAA;
  logic [3:0]  txd;
  logic        tx_en;
  logic        busy;
  logic [15:0] fcount;

  int passes = 0;
  int fails = 0;
  int total = 0;
  int cyc = 0;
  int en_cnt;
  logic [3:0] cap [0:143];
  int t0, t1, t2, t3, t4, w;

  mii_net #(.FRAME_PERIOD(P), .SRC_MAC(MAC), .ETHERTYPE(ET)) dut (
    .i_sys_clk(clk), .i_nreset(rst_n), .i_switches(sw),
    .o_mii_txd(txd), .o_mii_tx_en(tx_en), .o_busy(busy), .o_frame_count(fcount)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] seq_exp(input int n);
`ifdef MII_NET_SEQNUM_EN
    return 16'(n);
`else
    return 16'h0000;
`endif
  endfunction

  function automatic logic [7:0] exp_byte(input int i, input logic [16:0] s, input logic [15:0] q);
    logic [47:0] m;
    m = MAC;
    if (i < 7) return 8'h55;
    if (i == 7) return 8'hD5;
    if (i < 14) return 8'hFF;
    if (i < 20) return m[8*(19-i) +: 8];
    if (i == 20) return 8'h88;
    if (i == 21) return 8'hB5;
    if (i == 22) return {7'b0000000, s[16]};
    if (i == 23) return s[15:8];
    if (i == 24) return s[7:0];
    if (i == 25) return q[15:8];
    if (i == 26) return q[7:0];
    return 8'h00;
  endfunction

  function automatic logic [31:0] residue();
    logic [31:0] c;
    logic [3:0] d;
    c = 32'hFFFFFFFF;
    for (int k = 16; k < 144; k++) begin
      d = cap[k];
      for (int b = 0; b < 4; b++) begin
        if (c[0] ^ d[b]) c = {1'b0, c[31:1]} ^ 32'hEDB88320;
        else c = {1'b0, c[31:1]};
      end
    end
    return c;
  endfunction

  task automatic wait_start(output int at, output int waited);
    waited = 0;
    while (tx_en !== 1'b1 && waited < P + 20) begin
      @(negedge clk);
      waited++;
    end
    check("frame_start", {31'd0, tx_en}, 32'd1);
    at = cyc;
  endtask

  task automatic grab(input int tk, input logic [16:0] nsw);
    en_cnt = 0;
    for (int k = 0; k < 144; k++) begin
      if (k > 0) @(negedge clk);
      cap[k] = txd;
      if (tx_en === 1'b1) en_cnt++;
      if (k == tk) sw = nsw;
    end
    check("en_cycles", en_cnt, 32'd144);
    @(negedge clk);
    check("en_low_after", {31'd0, tx_en}, 32'd0);
    check("txd_zero_after", {28'd0, txd}, 32'd0);
    check("busy_low_after", {31'd0, busy}, 32'd0);
  endtask

  task automatic check_frame(input string name, input logic [16:0] s, input logic [15:0] q);
    for (int i = 0; i < 68; i++) begin
      check($sformatf("%s_byte%0d", name, i), {24'd0, cap[2*i+1], cap[2*i]}, {24'd0, exp_byte(i, s, q)});
    end
    check({name, "_residue"}, residue(), 32'hDEBB20E3);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_txd", {28'd0, txd}, 32'd0);
    check("rst_en", {31'd0, tx_en}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_count", {16'd0, fcount}, 32'd0);
    rst_n = 1'b1;

    wait_start(t0, w);
    check("first_edge_start", w, 32'd1);
    check("f0_busy_high", {31'd0, busy}, 32'd1);
    check("f0_nib0", {28'd0, txd}, 32'd5);
    grab(20, 17'h05A5A);
    check("count_f0", {16'd0, fcount}, 32'd1);
    check("f0_sfd_lo", {28'd0, cap[14]}, 32'h5);
    check("f0_sfd_hi", {28'd0, cap[15]}, 32'hD);
    check_frame("f0", 17'h0AAAA, 16'h0000);

    wait_start(t1, w);
    grab(-1, sw);
    check("period_f1", t1 - t0, P);
    check("count_f1", {16'd0, fcount}, 32'd2);
    check_frame("f1", 17'h05A5A, seq_exp(1));

    wait_start(t2, w);
    grab(-1, sw);
    check("period_f2", t2 - t1, P);
    check("count_f2", {16'd0, fcount}, 32'd3);
    check_frame("f2", 17'h05A5A, seq_exp(2));

    wait_start(t3, w);
    repeat (50) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_en", {31'd0, tx_en}, 32'd0);
    check("abort_txd", {28'd0, txd}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_count", {16'd0, fcount}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_start(t4, w);
    check("restart_first_edge", w, 32'd1);
    grab(-1, sw);
    check("count_restart", {16'd0, fcount}, 32'd1);
    check_frame("f4", 17'h05A5A, 16'h0000);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
